// File: rtl/simple_spi_slave.sv
// simple_spi_slave
// SPI Mode 0 (CPOL=0, CPHA=0) target. The external SCLK/CS_n/MOSI pins are
// oversampled in the clk domain. Bytes are shifted full-duplex, MSB first.
//
// Ports
//   clk, reset    system clock and synchronous active-high reset
//   tx_data       byte to send; it is written when tx_valid && tx_ready
//   tx_valid      write request for the one-byte TX holding register
//   tx_ready      holding register is empty
//   tx_underrun   one-cycle pulse when a byte load finds the holding register empty
//   rx_data       last complete received byte
//   rx_valid      one-cycle pulse when rx_data updates
//   busy          a transaction is active
//   spi_clk       SCLK pin (asynchronous)
//   spi_cs_n      chip select pin, active low (asynchronous)
//   spi_mosi      MOSI pin (asynchronous)
//   spi_miso      MISO data
//   spi_miso_oe   MISO output enable; equals busy
`timescale 1ns/1ps
module simple_spi_slave #(
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Synchronizer chains. SCLK and CS_n each have an extra delay flop for
  // edge detection. The flops reset to the idle pin levels, so reset does
  // not create a false edge.
  logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
  logic cs_meta_q, cs_sync_q, cs_dly_q;
  logic mosi_meta_q, mosi_sync_q;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       miso_q, miso_d;
  logic       byte_done_q, byte_done_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       tx_underrun_q, tx_underrun_d;

  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic       load;
  logic [7:0] rx_next;

  assign sclk_rise = sclk_sync_q & ~sclk_dly_q;
  assign sclk_fall = ~sclk_sync_q & sclk_dly_q;
  assign cs_fall   = ~cs_sync_q & cs_dly_q;
  assign cs_rise   = cs_sync_q & ~cs_dly_q;

  // Two-flop synchronizers plus the edge-detect delay stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_dly_q  <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_dly_q    <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      sclk_meta_q <= spi_clk;
      sclk_sync_q <= sclk_meta_q;
      sclk_dly_q  <= sclk_sync_q;
      cs_meta_q   <= spi_cs_n;
      cs_sync_q   <= cs_meta_q;
      cs_dly_q    <= cs_sync_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  // Transaction FSM and datapath next-state logic.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_shift_d    = tx_shift_q;
    miso_d        = miso_q;
    byte_done_d   = byte_done_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    tx_underrun_d = 1'b0;
    load          = 1'b0;
    rx_next       = {rx_shift_q[6:0], mosi_sync_q};

    case (state_q)
      IDLE: begin
        bit_cnt_d   = 3'd0;
        byte_done_d = 1'b0;
        if (cs_fall) begin
          load    = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // Abort: the partial byte and any unsent TX bits are dropped.
          state_d     = IDLE;
          bit_cnt_d   = 3'd0;
          byte_done_d = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_next;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d   = rx_next;
            rx_valid_d  = 1'b1;
            byte_done_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (byte_done_q) begin
            // The falling edge after a completed byte starts the next byte.
            byte_done_d = 1'b0;
            load        = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            miso_d     = tx_shift_q[6];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Byte load: take the holding register if it is full. Otherwise send
    // the default byte and flag an underrun.
    if (load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d    = DEFAULT_TX;
        tx_underrun_d = 1'b1;
      end
      miso_d = tx_shift_d[7];
    end

    // A write is accepted only into an empty register. A write in the same
    // cycle as an underrun load fills the register for the next byte.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      tx_shift_q    <= 8'h00;
      miso_q        <= 1'b0;
      byte_done_q   <= 1'b0;
      hold_q        <= 8'h00;
      hold_full_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_shift_q    <= tx_shift_d;
      miso_q        <= miso_d;
      byte_done_q   <= byte_done_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign tx_ready    = ~hold_full_q;
  assign tx_underrun = tx_underrun_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q == ACTIVE);
  assign spi_miso    = miso_q;
  assign spi_miso_oe = busy;

endmodule

// File: tb/tb_simple_spi_slave.sv
// tb_simple_spi_slave
// Random and directed SPI Mode 0 transactions against simple_spi_slave.
// The bench acts as the SPI master and models the TX holding register at the
// byte level.
// Expected received bytes go into a queue. A forked monitor pops that queue
// on each rx_valid and counts tx_underrun pulses.
`timescale 1ns/1ps
module tb_simple_spi_slave;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_underrun, rx_valid, busy, spi_miso, spi_miso_oe;
  logic [7:0] rx_data;
  logic       spi_clk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;

  int total = 0;
  int bad = 0;
  int underrun_seen = 0;
  int underrun_exp = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] mon_exp;

  // Byte-level model of the holding register and of the byte being shifted.
  logic       slot_full = 1'b0;
  logic [7:0] slot_val = 8'h00;
  logic [7:0] cur_tx = 8'h00;

  logic [7:0] mosi_bytes[4];
  logic [7:0] write_vals[4];
  logic [3:0] write_mask;

  // Free-running system clock.
  always #5 clk = ~clk;

  simple_spi_slave dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One load point: take the queued byte, or the default byte with an underrun.
  function automatic logic [7:0] load_byte();
    if (slot_full) begin
      slot_full = 1'b0;
      return slot_val;
    end
    underrun_exp++;
    return 8'hFF;
  endfunction

  task automatic tx_write(input logic [7:0] v);
    checkOutput("tx_ready_before_write", {31'd0, tx_ready}, {31'd0, !slot_full});
    tx_data  = v;
    tx_valid = 1'b1;
    wait_cycles(1);
    tx_valid  = 1'b0;
    slot_val  = v;
    slot_full = 1'b1;
  endtask

  task automatic shift_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      wait_cycles(HALF);
      spi_clk = 1'b1;
      got[i] = spi_miso;
      if (i == 0) rx_exp_q.push_back(b);
      wait_cycles(HALF);
      spi_clk = 1'b0;
    end
  endtask

  // One CS-framed transaction of nbytes. A non-zero abort_bits cuts the last
  // byte short. When simul is set, a write is presented in the exact cycle of
  // the CS-fall load.
  task automatic applyStimulus(input int nbytes, input int abort_bits, input logic simul, input logic [7:0] simul_val);
    logic [7:0] got;
    int n;
    spi_cs_n = 1'b0;
    if (simul) begin
      wait_cycles(2);
      checkOutput("tx_ready_at_cs_load", {31'd0, tx_ready}, 32'd1);
      tx_data  = simul_val;
      tx_valid = 1'b1;
      cur_tx = load_byte();
      slot_val  = simul_val;
      slot_full = 1'b1;
      wait_cycles(1);
      tx_valid = 1'b0;
      wait_cycles(HALF - 3);
    end else begin
      cur_tx = load_byte();
      wait_cycles(HALF);
    end
    for (int i = 0; i < nbytes; i++) begin
      wait_cycles(4);
      if (write_mask[i] && !slot_full) tx_write(write_vals[i]);
      n = (i == nbytes - 1 && abort_bits > 0) ? abort_bits : 8;
      shift_bits(mosi_bytes[i], n, got);
      if (n == 8) begin
        checkOutput("miso_byte", {24'd0, got}, {24'd0, cur_tx});
        cur_tx = load_byte();
      end
    end
    wait_cycles(HALF);
    spi_cs_n = 1'b1;
    wait_cycles(HALF);
    checkOutput("busy_after_cs", {31'd0, busy}, 32'd0);
    checkOutput("miso_oe_after_cs", {31'd0, spi_miso_oe}, 32'd0);
    checkOutput("underrun_count", underrun_seen, underrun_exp);
    checkOutput("rx_pending", rx_exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_miso"}, {31'd0, spi_miso}, 32'd0);
    checkOutput({tag, "_miso_oe"}, {31'd0, spi_miso_oe}, 32'd0);
    checkOutput({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    checkOutput({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    checkOutput({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
    checkOutput({tag, "_tx_underrun"}, {31'd0, tx_underrun}, 32'd0);
  endtask

  // Main sequence; the monitor is forked from the same process.
  initial begin
    logic [7:0] got;
    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (rx_valid) begin
            if (rx_exp_q.size() == 0) begin
              total++;
              bad++;
              $display("[TB] FAIL unexpected_rx_valid: got %0h, expected no strobe", rx_data);
            end else begin
              mon_exp = rx_exp_q.pop_front();
              checkOutput("rx_data", {24'd0, rx_data}, {24'd0, mon_exp});
            end
          end
          if (tx_underrun) underrun_seen++;
        end
      end
    join_none

    write_mask = 4'b0000;
    wait_cycles(4);
    check_reset_values("reset");
    reset = 1'b0;
    wait_cycles(4);

    $display("[TB] single byte");
    tx_write(8'hA5);
    mosi_bytes[0] = 8'h3C; write_vals[0] = 8'h5A; write_mask = 4'b0001;
    applyStimulus(1, 0, 1'b0, 8'h00);

    $display("[TB] back-to-back bytes");
    tx_write(8'h01);
    mosi_bytes[0] = 8'hF0; mosi_bytes[1] = 8'h0F;
    write_vals[0] = 8'h02; write_mask = 4'b0001;
    applyStimulus(2, 0, 1'b0, 8'h00);

    $display("[TB] underrun");
    mosi_bytes[0] = 8'hC6; mosi_bytes[1] = 8'h39; write_mask = 4'b0000;
    applyStimulus(2, 0, 1'b0, 8'h00);

    $display("[TB] abort");
    mosi_bytes[0] = 8'hB7; write_mask = 4'b0000;
    applyStimulus(1, 5, 1'b0, 8'h00);
    mosi_bytes[0] = 8'h81;
    applyStimulus(1, 0, 1'b0, 8'h00);

    $display("[TB] simultaneous write and load");
    mosi_bytes[0] = 8'h12; mosi_bytes[1] = 8'h34; write_mask = 4'b0000;
    applyStimulus(2, 0, 1'b1, 8'h77);

    $display("[TB] random transactions");
    for (int t = 0; t < 8; t++) begin
      if (($urandom % 2) == 1 && !slot_full) tx_write(8'($urandom));
      for (int k = 0; k < 4; k++) begin
        mosi_bytes[k] = 8'($urandom);
        write_vals[k] = 8'($urandom);
      end
      write_mask = 4'($urandom);
      applyStimulus(int'($urandom_range(3, 1)), 0, 1'b0, 8'h00);
    end

    $display("[TB] reset mid-byte");
    spi_cs_n = 1'b0;
    cur_tx = load_byte();
    wait_cycles(HALF);
    shift_bits(8'hC3, 3, got);
    reset = 1'b1;
    wait_cycles(1);
    spi_cs_n = 1'b1;
    wait_cycles(3);
    check_reset_values("midreset");
    reset = 1'b0;
    slot_full = 1'b0;
    wait_cycles(HALF);
    mosi_bytes[0] = 8'h55; write_mask = 4'b0000;
    applyStimulus(1, 0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
